// File: rtl/dot_matrix_scan_ctrl.sv
// Row-scan driver for a ROWS x COLS LED dot matrix with double-buffered frames and ghost blanking.
// Optional PWM dimming (i_Bright port) is compiled in when DM_DIMMING_EN is defined.
module dot_matrix_scan_ctrl #(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int SCAN_CYC    = 100000,
    parameter int BLANK_CYC   = 16,
    parameter int ROW_ACT_LOW = 1,
    parameter int COL_ACT_LOW = 0
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic                    i_Enable,
    input  logic                    i_Load,
    input  logic [ROWS*COLS-1:0]    i_Data,
`ifdef DM_DIMMING_EN
    input  logic [3:0]              i_Bright,
`endif
    output logic [ROWS-1:0]         o_DM_Row,
    output logic [COLS-1:0]         o_DM_Col,
    output logic                    o_fDone,
    output logic [$clog2(ROWS)-1:0] o_Row_Idx
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(SCAN_CYC);
    localparam int FW = ROWS * COLS;
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_CYC - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] shadow_q, shadow_d;
    logic [FW-1:0] disp_q, disp_d;
    logic          pend_q, pend_d;

    logic            frame_end;
    logic            visible;
    logic [ROWS-1:0] row_act;
    logic [COLS-1:0] col_sel;
    logic [COLS-1:0] col_act;
    logic            col_gate;

`ifdef DM_DIMMING_EN
    logic [3:0] pwm_q, pwm_d;
    logic [3:0] bright_q, bright_d;
`endif

    always_comb begin
        frame_end = i_Enable && (row_q == ROW_LAST) && (cnt_q == CNT_LAST);

        row_d = row_q;
        cnt_d = cnt_q;
        if (!i_Enable) begin
            row_d = '0;
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Swap uses the pre-load shadow, so a coincident load stays pending for one more frame.
        shadow_d = shadow_q;
        disp_d   = disp_q;
        pend_d   = pend_q;
        if (frame_end && pend_q) begin
            disp_d = shadow_q;
            pend_d = 1'b0;
        end
        if (i_Load) begin
            shadow_d = i_Data;
            pend_d   = 1'b1;
        end
    end

`ifdef DM_DIMMING_EN
    always_comb begin
        pwm_d    = i_Enable ? pwm_q + 1'b1 : pwm_q;
        bright_d = frame_end ? i_Bright : bright_q;
        col_gate = (bright_q == 4'hF) || (pwm_q < bright_q);
    end
`else
    assign col_gate = 1'b1;
`endif

    always_comb begin
        visible = i_Enable && (cnt_q >= CNT_BLANK);
        row_act = '0;
        col_sel = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (row_q == RW'(r)) begin
                row_act[r] = visible;
                col_sel    = disp_q[COLS*r +: COLS];
            end
        end
        col_act = (visible && col_gate) ? col_sel : '0;
    end

    assign o_DM_Row  = (ROW_ACT_LOW != 0) ? ~row_act : row_act;
    assign o_DM_Col  = (COL_ACT_LOW != 0) ? ~col_act : col_act;
    assign o_fDone   = frame_end;
    assign o_Row_Idx = row_q;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            row_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            disp_q   <= '0;
            pend_q   <= 1'b0;
        end else begin
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
        end
    end

`ifdef DM_DIMMING_EN
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            pwm_q    <= '0;
            bright_q <= 4'hF;
        end else begin
            pwm_q    <= pwm_d;
            bright_q <= bright_d;
        end
    end
`endif

endmodule

// File: tb/tb_dot_matrix_scan_ctrl.sv
// Randomised self-checking bench for dot_matrix_scan_ctrl (4x4, 8-cycle slots, 2-cycle blank).
// The reference model tracks elapsed enabled cycles and derives row/slot position arithmetically.
module tb_dot_matrix_scan_ctrl;

    localparam int R = 4;
    localparam int C = 4;
    localparam int S = 8;
    localparam int B = 2;
    localparam int F = R * S;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        ld    = 1'b0;
    logic [15:0] data  = '0;
`ifdef DM_DIMMING_EN
    logic [3:0]  bright = 4'hF;
`endif
    logic [3:0]  row;
    logic [3:0]  col;
    logic        fdone;
    logic [1:0]  idx;
    logic [10:0] got;

    assign got = {row, col, fdone, idx};

    dot_matrix_scan_ctrl #(
        .ROWS(R), .COLS(C), .SCAN_CYC(S), .BLANK_CYC(B), .ROW_ACT_LOW(1), .COL_ACT_LOW(0)
    ) dut (
        .i_Clk    (clk),
        .i_Rst    (rst_n),
        .i_Enable (en),
        .i_Load   (ld),
        .i_Data   (data),
`ifdef DM_DIMMING_EN
        .i_Bright (bright),
`endif
        .o_DM_Row (row),
        .o_DM_Col (col),
        .o_fDone  (fdone),
        .o_Row_Idx(idx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: t = cycles since scan (re)start, frame buffers as plain vectors.
    int unsigned t;
    logic [15:0] m_shadow;
    logic [15:0] m_disp;
    bit          m_pend;

    task automatic model_reset();
        t        = 0;
        m_shadow = '0;
        m_disp   = '0;
        m_pend   = 1'b0;
    endtask

    function automatic logic [10:0] expv();
        int unsigned ri = (t / S) % R;
        int unsigned cn = t % S;
        logic [15:0] d  = m_disp;
        logic [3:0]  r  = 4'hF;
        logic [3:0]  c  = 4'h0;
        logic        f;
        if (en && cn >= B) begin
            r[ri] = 1'b0;
            c     = d[4*ri +: 4];
        end
        f = en && (t % F == F - 1);
        return {r, c, f, 2'(ri)};
    endfunction

    task automatic adv();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (en && (t % F == F - 1) && m_pend) begin
                m_disp = m_shadow;
                m_pend = 1'b0;
            end
            if (ld) begin
                m_shadow = data;
                m_pend   = 1'b1;
            end
            t = en ? t + 1 : 0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        model_reset();
        #2;
        total++;
        if (got !== 11'b1111_0000_0_00) begin
            bad++;
            $display("FAIL reset_async got=%h exp=%h", got, 11'b1111_0000_0_00);
        end
        repeat (3) @(negedge clk);
        total++;
        if (got !== 11'b1111_0000_0_00) begin
            bad++;
            $display("FAIL reset_held got=%h exp=%h", got, 11'b1111_0000_0_00);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (got !== expv()) begin
                bad++;
                $display("FAIL reset_release t=%0d got=%h exp=%h", t, got, expv());
            end
            if (i == 2) begin
                total++;
                if (row !== 4'b1110 || col !== 4'h0) begin
                    bad++;
                    $display("FAIL reset_cycle2 row=%b col=%b exp row=1110 col=0000", row, col);
                end
            end
            adv();
        end
    endtask

    task automatic test_load_pattern();
        for (int i = 0; i < 2 * F; i++) begin
            ld   = (t == 4);
            data = (t == 4) ? 16'h8421 : 16'($urandom);
            #1;
            total++;
            if (got !== expv()) begin
                bad++;
                $display("FAIL load_pattern t=%0d got=%h exp=%h", t, got, expv());
            end
            if (t / F == 1 && t % S >= B) begin
                total++;
                if (col !== 4'(1 << ((t / S) % R))) begin
                    bad++;
                    $display("FAIL diag_frame1 t=%0d col=%b", t, col);
                end
            end
            adv();
        end
        ld = 1'b0;
    endtask

    task automatic test_fdone();
        int pulses   = 0;
        int expected = 0;
        for (int i = 0; i < 3 * F; i++) begin
            #1;
            if (t % F == F - 1) expected++;
            if (fdone) pulses++;
            total++;
            if (got !== expv()) begin
                bad++;
                $display("FAIL fdone_run t=%0d got=%h exp=%h", t, got, expv());
            end
            adv();
        end
        total++;
        if (pulses !== expected || expected != 3) begin
            bad++;
            $display("FAIL fdone_count got=%0d exp=%0d", pulses, expected);
        end
    endtask

    task automatic test_boundary_load();
        int unsigned start_frame;
        while (t % F != F - 1) begin
            #1;
            total++;
            if (got !== expv()) begin
                bad++;
                $display("FAIL bnd_seek t=%0d got=%h exp=%h", t, got, expv());
            end
            adv();
        end
        start_frame = t / F + 1;
        for (int i = 0; i < 2 * F + 1; i++) begin
            ld   = (i == 0);
            data = 16'hFFFF;
            #1;
            total++;
            if (got !== expv()) begin
                bad++;
                $display("FAIL bnd_load t=%0d got=%h exp=%h", t, got, expv());
            end
            if (t / F == start_frame + 1 && t % S >= B) begin
                total++;
                if (col !== 4'hF) begin
                    bad++;
                    $display("FAIL bnd_full t=%0d col=%b exp=1111", t, col);
                end
            end
            adv();
        end
        ld = 1'b0;
    endtask

    task automatic test_enable();
        int guard = 0;
        while (t % F != 2 * S + 4 && guard < 2 * F) begin
            #1;
            guard++;
            adv();
        end
        for (int i = 0; i < 14; i++) begin
            en   = !(i >= 1 && i <= 4);
            ld   = (i == 2);
            data = 16'h1234;
            #1;
            total++;
            if (got !== expv()) begin
                bad++;
                $display("FAIL enable t=%0d i=%0d got=%h exp=%h", t, i, got, expv());
            end
            if (i == 2) begin
                total++;
                if (row !== 4'hF || col !== 4'h0 || idx !== 2'd0) begin
                    bad++;
                    $display("FAIL disable_next row=%b col=%b idx=%0d exp 1111/0000/0", row, col, idx);
                end
            end
            adv();
        end
        en = 1'b1;
        ld = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            en   = ($urandom_range(0, 24) != 0);
            ld   = ($urandom_range(0, 11) == 0);
            data = 16'($urandom);
            #1;
            total++;
            if (got !== expv()) begin
                bad++;
                $display("FAIL random t=%0d got=%h exp=%h", t, got, expv());
            end
            adv();
        end
        en = 1'b1;
        ld = 1'b0;
    endtask

    task automatic test_async_reset();
        ld   = 1'b1;
        data = 16'hA5C3;
        #1;
        adv();
        ld = 1'b0;
        repeat (3) adv();
        rst_n = 1'b0;
        #1;
        total++;
        if (got !== 11'b1111_0000_0_00) begin
            bad++;
            $display("FAIL async_reset got=%h exp=%h", got, 11'b1111_0000_0_00);
        end
        adv();
        rst_n = 1'b1;
        for (int i = 0; i < 2 * F + 4; i++) begin
            #1;
            total++;
            if (got !== expv() || col !== 4'h0) begin
                bad++;
                $display("FAIL post_reset t=%0d got=%h exp=%h", t, got, expv());
            end
            adv();
        end
    endtask

    initial begin
        test_reset();
        test_load_pattern();
        test_fdone();
        test_boundary_load();
        test_enable();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
